// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU on-chip buffers: latency bounds, clear-FSM
// state type and the byte-enable merge used by every buffer flavour.
package npu_mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word any buffer may use with be_merge; callers cast in and out.
  localparam int MERGE_W = 1024;

  typedef logic [MERGE_W-1:0]   merge_word_t;
  typedef logic [MERGE_W/8-1:0] merge_be_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Bytes with be[i]=1 come from new_word, the rest from old_word.
  function automatic merge_word_t be_merge(input merge_word_t old_word,
                                           input merge_word_t new_word,
                                           input merge_be_t   be);
    merge_word_t res;
    for (int i = 0; i < MERGE_W / 8; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_dp_core.sv
// Raw simple dual-port array: byte-enabled write port and a registered read
// port. Written so synthesis maps it onto block RAM.
module sram_dp_core #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it is the job of the sweep engine
  // upstream, which keeps this block mappable onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // NOTE: non-blocking assignment in both processes means a same-edge read of
  // the address being written sees the old word; the bypass lives upstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sram_dp_pipe.sv
// Parametrised simple dual-port buffer: byte-enabled writes, optional
// write-first collision bypass, 1/2-cycle read latency and a clear engine.
module sram_dp_pipe
  import npu_mem_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16384,
  parameter int RD_LAT     = 1,
  parameter int WR_FIRST   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       clr_start,
  output logic                       clr_busy
);

  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam int                NB        = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > MERGE_W) begin : g_bad_data_w
    $fatal(1, "sram_dp_pipe: DATA_W=%0d must be a multiple of 8 in 8..%0d", DATA_W, MERGE_W);
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $fatal(1, "sram_dp_pipe: RD_LAT=%0d outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sram_dp_pipe: DEPTH=%0d must be a power of two >= 4", DEPTH);
  end

  clr_state_e        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              auto_pend;
  logic              clearing;
  logic              wr_acc;
  logic              rd_acc;

  assign clearing = (state == CLEAR);
  assign wr_acc   = wr_en && !clearing;
  assign rd_acc   = rd_en && !clearing;

  // ---------------------------------------------------------------------------
  // Clear engine. auto_pend turns reset release into a one-shot start request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      clr_busy  <= 1'b0;
      auto_pend <= (CLR_ON_RST != 0);
    end else begin
      auto_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start || auto_pend) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // The sweep owns the write port; user writes are dropped, not queued.
  logic              core_we;
  logic [NB-1:0]     core_be;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  assign core_we    = clearing || wr_acc;
  assign core_be    = clearing ? '1 : wr_be;
  assign core_waddr = clearing ? clr_cnt : wr_addr;
  assign core_wdata = clearing ? '0 : wr_data;

  sram_dp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (core_we),
    .wr_be   (core_be),
    .wr_addr (core_waddr),
    .wr_data (core_wdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_addr),
    .rd_data (core_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read stage 1: capture the colliding write alongside the array read. The
  // bypass registers only load on an accepted read so the stage holds its data.
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic              byp_hit;
  logic [NB-1:0]     byp_be;
  logic [DATA_W-1:0] byp_data;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      byp_hit  <= 1'b0;
      byp_be   <= '0;
      byp_data <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        byp_hit  <= (WR_FIRST != 0) && wr_acc && (wr_addr == rd_addr);
        byp_be   <= wr_be;
        byp_data <= wr_data;
      end
    end
  end

  assign s1_data = byp_hit
                 ? DATA_W'(be_merge(merge_word_t'(core_rdata),
                                    merge_word_t'(byp_data),
                                    merge_be_t'(byp_be)))
                 : core_rdata;

  // ---------------------------------------------------------------------------
  // Optional output register for RD_LAT=2.
  // ---------------------------------------------------------------------------
  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

endmodule

// File: tb/tb_sram_dp_pipe.sv
// Directed bench for sram_dp_pipe: two instances share stimulus, A with
// RD_LAT=1/WR_FIRST=0 and B with RD_LAT=2/WR_FIRST=1, both DEPTH=16.
module tb_sram_dp_pipe;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int NB     = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              wr_en, rd_en, clr_start;
  logic [NB-1:0]     wr_be;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] a_rd_data, b_rd_data;
  logic              a_rd_valid, b_rd_valid, a_clr_busy, b_clr_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_dp_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(1), .WR_FIRST(0), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_start(clr_start), .clr_busy(a_clr_busy)
  );

  sram_dp_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(2), .WR_FIRST(1), .CLR_ON_RST(1)) dut_b (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_start(clr_start), .clr_busy(b_clr_busy)
  );

  typedef struct {
    logic              we;
    logic [NB-1:0]     be;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              re;
    logic [ADDR_W-1:0] ra;
    logic              av;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [DATA_W-1:0] bd;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    wr_be = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  function automatic vec_t mk(input logic we, input logic [NB-1:0] be, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] ra,
                              input logic av, input logic [DATA_W-1:0] ad,
                              input logic bv, input logic [DATA_W-1:0] bd);
    vec_t v;
    v.we = we; v.be = be; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
    return v;
  endfunction

  // Counts busy cycles of both instances and any read strobe over a fixed window.
  task automatic count_sweep(input string tag);
    int na = 0;
    int nb = 0;
    int nv = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_clr_busy) na++;
      if (b_clr_busy) nb++;
      if (a_rd_valid || b_rd_valid) nv++;
      @(negedge clk);
    end
    check({tag, "_busy_a"}, 64'(na), 64'(DEPTH));
    check({tag, "_busy_b"}, 64'(nb), 64'(DEPTH));
    check({tag, "_valid"}, 64'(nv), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;
    int na;
    int nb;
    int nv;

    // Columns: we be wa wd | re ra | A valid,data (this row) | B valid,data (previous row)
    vecs[0]  = mk(1, 8'hFF, 5, 64'h1122334455667788, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 8'h0F, 5, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 64'h0, 1, 5, 1, 64'h11223344AAAAAAAA, 0, 0);
    vecs[3]  = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 1, 64'h11223344AAAAAAAA);
    vecs[4]  = mk(1, 8'h01, 3, 64'hFFFFFFFFFFFFFFFF, 1, 3, 1, 64'h0, 0, 0);
    vecs[5]  = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 1, 64'h00000000000000FF);
    vecs[6]  = mk(0, 8'h00, 0, 64'h0, 1, 3, 1, 64'h00000000000000FF, 0, 0);
    vecs[7]  = mk(1, 8'hFF, 0, 64'h0, 0, 0, 0, 0, 1, 64'h00000000000000FF);
    vecs[8]  = mk(1, 8'hFF, 1, 64'h1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 8'hFF, 2, 64'h2, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 8'hFF, 3, 64'h3, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 8'h00, 0, 64'h0, 1, 0, 1, 64'h0, 0, 0);
    vecs[12] = mk(0, 8'h00, 0, 64'h0, 1, 1, 1, 64'h1, 1, 64'h0);
    vecs[13] = mk(0, 8'h00, 0, 64'h0, 1, 2, 1, 64'h2, 1, 64'h1);
    vecs[14] = mk(0, 8'h00, 0, 64'h0, 1, 3, 1, 64'h3, 1, 64'h2);
    vecs[15] = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 1, 64'h3);
    vecs[16] = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 8'h00, 0, 64'h0, 1, 5, 1, 64'h11223344AAAAAAAA, 0, 0);
    vecs[18] = mk(1, 8'hFF, 5, 64'h0, 0, 0, 0, 0, 1, 64'h11223344AAAAAAAA);
    vecs[19] = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 8'hFF, 6, 64'h77, 1, 5, 1, 64'h0, 0, 0);
    vecs[21] = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 1, 64'h0);
    vecs[22] = mk(1, 8'h00, 2, 64'hFFFF, 1, 2, 1, 64'h2, 0, 0);
    vecs[23] = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 1, 64'h2);
    vecs[24] = mk(0, 8'h00, 0, 64'h0, 1, 2, 1, 64'h2, 0, 0);
    vecs[25] = mk(0, 8'h00, 0, 64'h0, 0, 0, 0, 0, 1, 64'h2);

    // Reset values, then the automatic sweep on release.
    idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_data", a_rd_data, 64'h0);
    check("rst_b_data", b_rd_data, 64'h0);
    check_bit("rst_a_valid", a_rd_valid, 1'b0);
    check_bit("rst_b_valid", b_rd_valid, 1'b0);
    check_bit("rst_a_busy", a_clr_busy, 1'b0);
    check_bit("rst_b_busy", b_clr_busy, 1'b0);
    rstn = 1'b1;
    count_sweep("auto_clr");

    // Every word reads back as zero, one cycle after rd_en on A.
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      rd_addr = ADDR_W'(i);
      @(negedge clk);
      check_bit($sformatf("clr_rd_valid_%0d", i), a_rd_valid, 1'b1);
      check($sformatf("clr_rd_data_%0d", i), a_rd_data, 64'h0);
    end
    idle();
    repeat (2) @(negedge clk);

    // Vector table; rd_data must hold its last valid value between strobes.
    a_hold = '0;
    b_hold = '0;
    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].we; wr_be = vecs[i].be; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      @(negedge clk);
      if (vecs[i].av) a_hold = vecs[i].ad;
      if (vecs[i].bv) b_hold = vecs[i].bd;
      check_bit($sformatf("vec%0d_a_valid", i), a_rd_valid, vecs[i].av);
      check_bit($sformatf("vec%0d_b_valid", i), b_rd_valid, vecs[i].bv);
      check($sformatf("vec%0d_a_data", i), a_rd_data, a_hold);
      check($sformatf("vec%0d_b_data", i), b_rd_data, b_hold);
    end
    idle();

    // Lockout: accesses and a second clr_start during the sweep are ignored.
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    na = 0; nb = 0; nv = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_clr_busy) na++;
      if (b_clr_busy) nb++;
      if (a_rd_valid || b_rd_valid) nv++;
      clr_start = (k == 4);
      wr_en   = (k >= 10 && k <= 13);
      wr_be   = 8'hFF;
      wr_addr = 4'd7;
      wr_data = 64'h55;
      rd_en   = (k >= 10 && k <= 13);
      rd_addr = 4'd7;
      @(negedge clk);
    end
    idle();
    check("lock_busy_a", 64'(na), 64'(DEPTH));
    check("lock_busy_b", 64'(nb), 64'(DEPTH));
    check("lock_valid", 64'(nv), 64'd0);
    rd_en = 1'b1; rd_addr = 4'd7;
    @(negedge clk);
    idle();
    check_bit("lock_rd7_a_valid", a_rd_valid, 1'b1);
    check("lock_rd7_a_data", a_rd_data, 64'h0);
    @(negedge clk);
    check_bit("lock_rd7_b_valid", b_rd_valid, 1'b1);
    check("lock_rd7_b_data", b_rd_data, 64'h0);

    // Put a non-zero word on rd_data so the asynchronous reset is visible.
    wr_en = 1'b1; wr_be = 8'hFF; wr_addr = 4'd1; wr_data = 64'h1234;
    @(negedge clk);
    idle();
    rd_en = 1'b1; rd_addr = 4'd1;
    @(negedge clk);
    idle();
    @(negedge clk);
    check("pre_rst_a_data", a_rd_data, 64'h1234);
    check("pre_rst_b_data", b_rd_data, 64'h1234);

    // Reset in the middle of a sweep, then a fresh automatic sweep.
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (7) @(negedge clk);
    check_bit("mid_busy_a", a_clr_busy, 1'b1);
    check_bit("mid_busy_b", b_clr_busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check_bit("mid_rst_busy_a", a_clr_busy, 1'b0);
    check_bit("mid_rst_busy_b", b_clr_busy, 1'b0);
    check_bit("mid_rst_valid_a", a_rd_valid, 1'b0);
    check_bit("mid_rst_valid_b", b_rd_valid, 1'b0);
    check("mid_rst_data_a", a_rd_data, 64'h0);
    check("mid_rst_data_b", b_rd_data, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    count_sweep("re_clr");

    rd_en = 1'b1; rd_addr = 4'd1;
    @(negedge clk);
    check_bit("post_rd1_valid", a_rd_valid, 1'b1);
    check("post_rd1_data", a_rd_data, 64'h0);
    rd_addr = 4'd15;
    @(negedge clk);
    idle();
    check_bit("post_rd15_valid", a_rd_valid, 1'b1);
    check("post_rd15_data", a_rd_data, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_pipe.md
Name: sram_dp_pipe

Overview:
Parametrised simple dual-port SRAM: one write port, one read port, single clock. It generalises the fixed 16kx64 buffer with the following:
- configurable width and depth
- byte write enables
- selectable read-during-write collision mode
- 1- or 2-cycle read latency with a valid strobe
- a hardware clear engine that zeroes the array after reset or on request

It serves as the NPU's weight, activation and partial-sum buffers.

Parameters:
DATA_W, 64, data width in bits; multiple of 8
DEPTH, 16384, number of words; power of two, minimum 4
ADDR_W, $clog2(DEPTH), address width; derived, not overridden
RD_LAT, 1, read latency in cycles; 1 or 2 (2 adds an output register)
WR_FIRST, 0, same-address collision: 0 returns old data, 1 returns new data byte-merged
CLR_ON_RST, 1, 1 starts a clear sweep automatically on reset release

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data; valid when rd_valid=1
rd_valid  out  1  one-cycle strobe, RD_LAT cycles after an accepted rd_en
clr_start  in  1  pulse to request a full-array clear
clr_busy  out  1  high while the clear sweep runs

Behaviour:
- Reset (rstn=0, asynchronous):
  - rd_data=0, rd_valid=0.
  - clr_busy=0, state=IDLE, clear counter=0. All pipeline registers are 0.
  - The array itself is not reset.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start=1. After reset release, IDLE -> CLEAR also happens on the first clk edge when CLR_ON_RST=1.
  - In CLEAR, one word is written per cycle: ram[cnt] <= 0, then cnt increments.
  - When cnt=DEPTH-1 is written: cnt -> 0, state -> IDLE.
  - A sweep takes exactly DEPTH cycles. clr_busy equals (state==CLEAR), registered.
  - clr_start while CLEAR is ignored; the sweep does not restart.
  - Reset mid-sweep aborts immediately. The sweep restarts from 0 only if CLR_ON_RST=1.
- Accesses during CLEAR:
  - wr_en is ignored (dropped, not queued).
  - rd_en is ignored and rd_valid stays 0.
  - An access already in the read pipeline when CLEAR begins completes normally.
- Write:
  - When wr_en=1 and not CLEAR, each byte i with wr_be[i]=1 is written to ram[wr_addr] at the clock edge.
  - wr_be=0 leaves the word unchanged.
- Read:
  - An accepted rd_en samples ram[rd_addr] at the edge.
  - RD_LAT=1: rd_data and rd_valid appear on the next cycle.
  - RD_LAT=2: an extra register stage; data appears 2 cycles after rd_en.
  - Reads are fully pipelined: rd_en may be asserted every cycle.
  - rd_data holds its last value when rd_valid=0.
- Collision (wr_en and rd_en on the same cycle, wr_addr==rd_addr):
  - WR_FIRST=0: old word returned.
  - WR_FIRST=1: bytes with wr_be=1 come from wr_data; the other bytes are old. A bypass mux in the read stage implements this.
  - Only same-cycle collisions are bypassed. A write on a later cycle never changes data already sampled.
- Address wrap: none. Addresses are ADDR_W bits and every value is valid.

Decomposition:
- Shared package npu_mem_pkg holds:
  - localparams RD_LAT_MIN=1 and RD_LAT_MAX=2
  - typedef of the clear-FSM state enum (IDLE, CLEAR)
  - function be_merge(old, new, be), reused by other buffers.
- One sub-module, sram_dp_core, holds the raw byte-enabled array with no reset: the write port plus a registered read.
- sram_dp_pipe adds the clear FSM, the collision bypass, the latency pipeline and rd_valid.
- Parameter checks (DATA_W%8, RD_LAT range) go in an initial block that stops elaboration on violation.

Test Plan:
- Reset, then clear; CLR_ON_RST=1, DEPTH=16 -> clr_busy is high for exactly 16 cycles. Afterwards, reading addresses 0..15 returns 0 with rd_valid 1 cycle after each rd_en (RD_LAT=1).
- Byte enables, DATA_W=64 -> write 0x1122334455667788 to address 5 with wr_be=0xFF, then 0xAAAAAAAAAAAAAAAA with wr_be=0x0F. Read of address 5 = 0x11223344AAAAAAAA.
- Collision with WR_FIRST=0 and WR_FIRST=1, using address 3 holding 0x0 and a write of 0xFFFF_FFFF_FFFF_FFFF with wr_be=0x01 on the same cycle as a read of address 3 -> WR_FIRST=0 reads 0x0; WR_FIRST=1 reads 0x00000000000000FF.
- Back-to-back reads with RD_LAT=2 -> rd_en on 4 consecutive cycles for addresses 0..3 (each preloaded with its own address) gives rd_valid on 4 consecutive cycles starting 2 cycles later, with data 0,1,2,3 in order.
- Access lockout, DEPTH=16 -> clr_start pulse with wr_en to address 7 (data 0x55) and rd_en during the sweep: the write is dropped and rd_valid stays 0. After the sweep, address 7 reads 0. A second clr_start mid-sweep does not extend clr_busy beyond 16 cycles.
- Reset mid-sweep -> rstn low at sweep cycle 8 clears clr_busy, rd_valid and rd_data asynchronously. On release with CLR_ON_RST=1, a fresh 16-cycle sweep begins at address 0.
